pio_uart_rx_host: RTL
=====================

# pio_uart_rx_host

Host-side controller for a PIO state machine running a UART receive program; the receive-direction counterpart of the TX push loop. After reset it streams the program image and configuration words into the PIO. It then drains the selected machine's RX FIFO with PULL actions and extracts each received byte from the 32-bit word. Bytes go to a 4-entry first-word-fall-through buffer with a valid/ready stream output. The block sits beside the `pio` instance in a top level and owns its `din`/`index`/`action`/`mindex` inputs.

## Interface
- `PROG_FILE`, "uart_rx.mem": hex image, 32 × 16-bit instructions.
- `CONF_FILE`, "rx_conf.mem": hex image, 32 × 36-bit words; [35:32] = action, [31:0] = data.
- `CONF_LEN`, 6: number of config words issued, 0..32.
- `SM`, 0: machine index driven on `pio_mindex` and used to select `pio_rx_empty`, 0..3.
- `BYTE_LSB`, 24: bit position of the received byte within `pio_dout`. The right-shifting ISR leaves it in [31:24].
- `PULL_ACT`, 5: action code for "pop RX FIFO of `pio_mindex` onto `dout`".
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `pio_din` output 32: data to PIO.
- `pio_index` output 5: instruction index to PIO.
- `pio_action` output 4: action to PIO. 0 = none, 1 = load instruction, others from the config image, `PULL_ACT` = pull.
- `pio_mindex` output 2: constant `SM`.
- `pio_dout` input 32: PIO output word.
- `pio_rx_empty` input 4: per-machine RX FIFO empty flags.
- `byte_data` output 8: head byte of the output buffer.
- `byte_valid` output 1: buffer non-empty.
- `byte_ready` input 1: consumer accepts head byte when `byte_valid` is also high.
- `running` output 1: high once configuration is complete.
- `stall_cnt` output 8: saturating count of cycles in which RX data was pending but the buffer was full.

## Operation
- States: LOAD → CONF → POLL → PULL → WAIT → CAPTURE → POLL.
- **LOAD**
  - Each cycle: `pio_action`=1, `pio_index`=p, `pio_din`={16'b0, prog[p]}, p increments.
  - After p=31 is issued, go to CONF.
- **CONF**
  - Each cycle c < `CONF_LEN`: `pio_action`=conf[c][35:32], `pio_din`=conf[c][31:0].
  - When c == `CONF_LEN`: `pio_action`=0, `running`=1, go to POLL.
  - `CONF_LEN`=0 passes through CONF in one cycle.
- **POLL**
  - If `pio_rx_empty[SM]`=0 and the buffer count < 4, go to PULL.
  - If `pio_rx_empty[SM]`=0 and the buffer is full, increment `stall_cnt` (saturates at 255) and stay in POLL. The PIO FIFO provides backpressure; no data is dropped by this block.
- **PULL**: `pio_action`=`PULL_ACT` for exactly one cycle.
- **WAIT**: `pio_action`=0. This one-cycle gap lets `dout` and `rx_empty` update.
- **CAPTURE**
  - Write `pio_dout[BYTE_LSB+7:BYTE_LSB]` into the buffer, then return to POLL.
  - A slot is always free, because the count was < 4 at the pull decision and reads only decrease it.
- **Buffer**
  - 4 entries, FIFO order, 2-bit pointers wrapping 3→0, 3-bit count.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - Read when empty is ignored.
- **Outputs**: `pio_mindex` is always `SM`. `pio_index` holds its last value outside LOAD.

## Timing
- **Reset values**: `pio_din`=0, `pio_index`=0, `pio_action`=0, `pio_mindex`=`SM`, `byte_valid`=0, `byte_data`=0, `running`=0, `stall_cnt`=0, state=LOAD, p=c=0, buffer empty.
- Reset mid-operation discards buffered bytes and restarts LOAD. A pull already issued is lost.
- All outputs are registered.
- **LOAD**: occupies cycles 1..32 after reset deassertion.
- **CONF**: occupies `CONF_LEN`+1 cycles; `running` rises on the last of them.
- **Per byte**: POLL decision at cycle t, PULL at t+1, WAIT at t+2, CAPTURE at t+3, `byte_valid` high at t+4. Minimum spacing is 4 cycles per byte.
- **Output handshake**: `byte_data` is stable while `byte_valid`=1 and `byte_ready`=0. The head advances on the cycle after a handshake.

## Test plan
- **Load and config**: release reset with `CONF_LEN`=6.
  - Expect 32 cycles of action=1 with index 0..31 and `din`=prog words.
  - Then 6 config words in order, then action=0 and `running`=1 at cycle 39.
- **Single byte**: model the PIO returning `pio_dout`=32'h4100_0000 after a pull, with `rx_empty[0]` going 0 then 1.
  - Expect exactly one PULL pulse.
  - Expect `byte_data`=8'h41 and `byte_valid`=1 four cycles after the POLL decision.
- **Burst with `byte_ready`=1**: bytes 0x30..0x39 queued in the model. Expect 10 bytes in order at a spacing of 4 cycles, with `stall_cnt`=0.
- **Backpressure**: `byte_ready`=0 with 6 bytes queued.
  - Expect exactly 4 pulls, `byte_valid` held high and `byte_data` stable.
  - `stall_cnt` increments each cycle. After `byte_ready`=1, all 6 bytes arrive in order.
- **Simultaneous read and write at count 3**: count stays 3 and order is preserved.
- **Reset mid-burst**: assert `reset` during WAIT. Expect all outputs at their reset values next cycle and LOAD restarting at index 0.

Source files
------------

// File: rtl/pio_uart_rx_host_if.sv
// Byte stream from the RX host: head byte, valid, and consumer ready.
// master drives byte_data/byte_valid; slave drives byte_ready.
interface pio_uart_rx_host_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/pio_uart_rx_host.sv
// pio_uart_rx_host: loads a PIO program and config words, then pulls RX
// words from machine SM and queues the received bytes in a 4-deep FWFT.
// Ports: clk, reset (sync, high); pio_din/index/action/mindex to PIO;
// pio_dout, pio_rx_empty from PIO; rx byte stream; running; stall_cnt.
// PROG_IMAGE packs 32 x 16-bit words (word p at [16p+:16]);
// CONF_IMAGE packs 32 x 36-bit words {action, data} (word c at [36c+:36]).
module pio_uart_rx_host #(
  parameter logic [511:0]  PROG_IMAGE = '0,
  parameter logic [1151:0] CONF_IMAGE = '0,
  parameter int            CONF_LEN   = 6,
  parameter int            SM         = 0,
  parameter int            BYTE_LSB   = 24,
  parameter logic [3:0]    PULL_ACT   = 4'd5
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        pio_din,
  output logic [4:0]         pio_index,
  output logic [3:0]         pio_action,
  output logic [1:0]         pio_mindex,
  input  logic [31:0]        pio_dout,
  input  logic [3:0]         pio_rx_empty,
  pio_uart_rx_host_if.master rx,
  output logic               running,
  output logic [7:0]         stall_cnt
);
  localparam logic [5:0] CLEN = 6'(CONF_LEN);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CONF,
    S_POLL,
    S_PULL,
    S_WAIT,
    S_CAPT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  p_q, p_d;
  logic [5:0]  c_q, c_d;
  logic [31:0] din_q, din_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  act_q, act_d;
  logic        run_q, run_d;
  logic [7:0]  stl_q, stl_d;

  logic [7:0]  mem_q [4];
  logic [1:0]  wp_q, wp_d;
  logic [1:0]  rp_q, rp_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [7:0]  hd_q, hd_d;
  logic        wr, rd;
  logic [7:0]  wbyte;
  logic [35:0] conf_w;
  logic        pending;
  logic        unused_in;

  assign wbyte     = pio_dout[BYTE_LSB +: 8];
  assign conf_w    = CONF_IMAGE[36 * c_q[4:0] +: 36];
  assign pending   = ~pio_rx_empty[SM];
  assign unused_in = ^{pio_dout, pio_rx_empty};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    din_d   = din_q;
    idx_d   = idx_q;
    act_d   = 4'd0;
    run_d   = run_q;
    stl_d   = stl_q;
    wr      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        act_d = 4'd1;
        idx_d = p_q;
        din_d = {16'b0, PROG_IMAGE[{p_q, 4'b0} +: 16]};
        p_d   = p_q + 5'd1;
        if (p_q == 5'd31) state_d = S_CONF;
      end
      S_CONF: begin
        if (c_q == CLEN) begin
          run_d   = 1'b1;
          state_d = S_POLL;
        end else begin
          act_d = conf_w[35:32];
          din_d = conf_w[31:0];
          c_d   = c_q + 6'd1;
        end
      end
      S_POLL: begin
        if (pending) begin
          if (cnt_q != 3'd4) begin
            act_d   = PULL_ACT;
            state_d = S_PULL;
          end else if (stl_q != 8'hff) begin
            stl_d = stl_q + 8'd1;
          end
        end
      end
      // PIO executes the pull at the end of this cycle; WAIT lets
      // dout and rx_empty settle before they are used.
      S_PULL: state_d = S_WAIT;
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        wr      = 1'b1;
        state_d = S_POLL;
      end
      default: state_d = S_LOAD;
    endcase

    rd    = vld_q & rx.byte_ready;
    cnt_d = cnt_q + 3'(wr) - 3'(rd);
    wp_d  = wp_q + 2'(wr);
    rp_d  = rp_q + 2'(rd);
    vld_d = (cnt_d != 3'd0);
    // Registered head: bypass the incoming byte when it lands on the
    // slot that becomes the head; hold the last byte when empty.
    hd_d = hd_q;
    if (vld_d) begin
      if (wr && (wp_q == rp_d)) hd_d = wbyte;
      else                      hd_d = mem_q[rp_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      p_q     <= 5'd0;
      c_q     <= 6'd0;
      din_q   <= 32'd0;
      idx_q   <= 5'd0;
      act_q   <= 4'd0;
      run_q   <= 1'b0;
      stl_q   <= 8'd0;
      wp_q    <= 2'd0;
      rp_q    <= 2'd0;
      cnt_q   <= 3'd0;
      vld_q   <= 1'b0;
      hd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      din_q   <= din_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      run_q   <= run_d;
      stl_q   <= stl_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      hd_q    <= hd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wbyte;
  end

  assign pio_din       = din_q;
  assign pio_index     = idx_q;
  assign pio_action    = act_q;
  assign pio_mindex    = 2'(SM);
  assign running       = run_q;
  assign stall_cnt     = stl_q;
  assign rx.byte_data  = hd_q;
  assign rx.byte_valid = vld_q;
endmodule
